// File: rtl/iq_issue_ctl.sv
// In-order issue controller for the instruction-queue extract side: grants the longest
// in-order head prefix that fits the FU ports. Optional `IQ_ISSUE_STATS_EN` adds stat counters.
module iq_issue_ctl #(
  parameter int EXT_COUNT    = 4,
  parameter int ALU_PORTS    = 2,
  parameter int MEM_PORTS    = 1,
  parameter int DIV_LATENCY  = 12,
  parameter int FLUSH_HOLD   = 2,
  parameter int EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [EXT_COUNT-1:0]      head_valid,
  input  logic [2*EXT_COUNT-1:0]    head_class,
  input  logic                      mem_ready,
  input  logic                      be_stall,
  output logic                      ext_enable,
  output logic [EXTCOUNTLOG2-1:0]   ext_consumed,
  output logic [EXT_COUNT-1:0]      issue_valid,
  output logic                      div_busy
`ifdef IQ_ISSUE_STATS_EN
  ,
  output logic [31:0]               stat_issued,
  output logic [31:0]               stat_stall_cycles
`endif
);

  localparam int HW = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
  localparam int DW = $clog2(DIV_LATENCY + 1);

  localparam logic [1:0] CL_ALU    = 2'b00;
  localparam logic [1:0] CL_MEM    = 2'b01;
  localparam logic [1:0] CL_MULDIV = 2'b10;
  localparam logic [1:0] CL_BRANCH = 2'b11;

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [HW-1:0]        hold_cnt, hold_nxt;
  logic [DW-1:0]        div_cnt;
  logic                 unit_busy;
  logic                 issue_en;
  logic                 div_grant;
  logic                 scan_on;
  logic                 ok;
  logic                 is_branch;
  logic [EXT_COUNT-1:0] grant;
  int                   alu_n;
  int                   mem_n;
  int                   n_cnt;

  assign unit_busy = (div_cnt != '0);
  assign issue_en  = (state == RUN) && !flush && !be_stall && !reset;

  // In-order grant scan: the first entry that cannot issue ends the group.
  always_comb begin
    grant     = '0;
    alu_n     = 0;
    mem_n     = 0;
    n_cnt     = 0;
    div_grant = 1'b0;
    scan_on   = issue_en;
    ok        = 1'b0;
    is_branch = 1'b0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      ok        = 1'b0;
      is_branch = 1'b0;
      if (scan_on && head_valid[i]) begin
        case (head_class[2*i +: 2])
          CL_ALU:    ok = (alu_n < ALU_PORTS);
          CL_MEM:    ok = mem_ready && (mem_n < MEM_PORTS);
          CL_MULDIV: ok = !unit_busy && !div_grant;
          CL_BRANCH: begin
            ok        = 1'b1;
            is_branch = 1'b1;
          end
          default:   ok = 1'b0;
        endcase
      end
      if (ok) begin
        grant[i] = 1'b1;
        n_cnt    = n_cnt + 1;
        case (head_class[2*i +: 2])
          CL_ALU:    alu_n = alu_n + 1;
          CL_MEM:    mem_n = mem_n + 1;
          CL_MULDIV: div_grant = 1'b1;
          default:   ;
        endcase
        if (is_branch) scan_on = 1'b0;
      end else begin
        scan_on = 1'b0;
      end
    end
  end

  assign issue_valid  = grant;
  assign ext_enable   = (n_cnt != 0);
  assign ext_consumed = (n_cnt != 0) ? EXTCOUNTLOG2'(n_cnt - 1) : '0;
  assign div_busy     = unit_busy && !reset;

  // Flush hold window: a flush in HOLD restarts the full window.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      RUN: begin
        if (flush) begin
          state_nxt = HOLD;
          hold_nxt  = HW'(FLUSH_HOLD - 1);
        end
      end
      HOLD: begin
        if (flush) begin
          hold_nxt = HW'(FLUSH_HOLD - 1);
        end else if (hold_cnt == '0) begin
          state_nxt = RUN;
        end else begin
          hold_nxt = hold_cnt - HW'(1);
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= RUN;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Divider occupancy runs regardless of flush so an in-flight divide stays accounted for.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_grant) begin
      div_cnt <= DW'(DIV_LATENCY);
    end else if (div_cnt != '0) begin
      div_cnt <= div_cnt - DW'(1);
    end
  end

`ifdef IQ_ISSUE_STATS_EN
  logic [31:0] issued_q;
  logic [31:0] stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_q + 32'(n_cnt);
      if (head_valid[0] && (n_cnt == 0)) stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_issued       = reset ? '0 : issued_q;
  assign stat_stall_cycles = reset ? '0 : stall_q;
`endif

endmodule

// File: doc/iq_issue_ctl.md
# iq_issue_ctl

In-order issue controller on the extract side of the instruction-queue circular buffer. Each cycle it examines the `EXT_COUNT` head entries, grants the longest in-order prefix that fits the available functional-unit ports, and drives the queue's extract handshake. It also tracks multicycle divider occupancy and blocks issue during a post-flush hold window.

## Interface
- `EXT_COUNT`, 4: head window width; must match the queue's extract width.
- `ALU_PORTS`, 2: maximum ALU-class grants per cycle (1..EXT_COUNT).
- `MEM_PORTS`, 1: maximum MEM-class grants per cycle (1..EXT_COUNT).
- `DIV_LATENCY`, 12: MULDIV unit occupancy in cycles after issue (≥1).
- `FLUSH_HOLD`, 2: issue-blocked cycles following a flush (≥1).
- `EXTCOUNTLOG2`, $clog2(EXT_COUNT): width of `ext_consumed`.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `flush` in 1: pipeline flush, same cycle the queue is flushed.
- `head_valid` in EXT_COUNT: bit i = queue head entry i valid.
- `head_class` in 2*EXT_COUNT: bits [2i+1:2i] = class of entry i (00 ALU, 01 MEM, 10 MULDIV, 11 BRANCH).
- `mem_ready` in 1: LSU can accept a MEM op this cycle.
- `be_stall` in 1: backend stall; blocks all issue.
- `ext_enable` out 1: extract request to the queue.
- `ext_consumed` out EXTCOUNTLOG2: entries extracted minus one.
- `issue_valid` out EXT_COUNT: bit i = head entry i issued this cycle.
- `div_busy` out 1: MULDIV unit occupied.

## Operation
- Grant scan, combinational, i = 0 upward. The scan stops at the first entry that is not granted. Entry i is granted iff all of the following hold:
  - every entry j < i is granted;
  - `head_valid[i]` is 1;
  - class-specific condition:
    - ALU: ALU grants so far < `ALU_PORTS`.
    - MEM: `mem_ready`, and MEM grants so far < `MEM_PORTS`.
    - MULDIV: `div_busy` is 0, and no MULDIV granted earlier this cycle.
    - BRANCH: always grantable. It terminates the group, so no entry after a granted BRANCH is granted.
- Issue enable: `issue_en = (state==RUN) & ~flush & ~be_stall & ~reset`. When `issue_en` is 0, all grants are forced to 0.
- Outputs:
  - n = number of granted entries.
  - `issue_valid` = grant vector; it is always a contiguous prefix of ones.
  - `ext_enable = (n != 0)`.
  - `ext_consumed = n-1` (n ≥ 1), else 0.
- FSM, two states:
  - RUN → HOLD on `flush`; `hold_cnt` ← `FLUSH_HOLD`-1.
  - HOLD: `hold_cnt` decrements each cycle. HOLD → RUN when `hold_cnt`==0 and `flush`==0.
  - `flush` while in HOLD reloads `hold_cnt` ← `FLUSH_HOLD`-1.
- Divider counter `div_cnt`, width $clog2(DIV_LATENCY+1):
  - Loaded with `DIV_LATENCY` on the edge ending a cycle that grants MULDIV.
  - Otherwise decrements while nonzero.
  - `div_busy = (div_cnt != 0)`.
  - Independent of FSM and `flush`: an in-flight divide keeps the unit occupied through a flush.
- Reset, synchronous: `state`=RUN, `hold_cnt`=0, `div_cnt`=0. While `reset` is high, all outputs are 0. Reset mid-divide or mid-HOLD clears the state on the next edge.

## Timing
- Zero-latency issue: grants depend combinationally on `head_*`, `mem_ready`, `be_stall`, `flush` and registered state. The queue consumes on the same edge.
- Flush at cycle t: no issue in cycles t through t+`FLUSH_HOLD`; first possible issue is cycle t+`FLUSH_HOLD`+1.
- MULDIV granted at cycle t: `div_busy`=1 for cycles t+1..t+`DIV_LATENCY`; the next MULDIV can be granted at t+`DIV_LATENCY`+1.
- `ext_consumed` never exceeds the count of valid head entries, because grants require `head_valid`. The queue's empty/full handling needs no extra guard.
- All-invalid head window, or first entry blocked: `ext_enable`=0, `issue_valid`=0.

## Configuration
- `IQ_ISSUE_STATS_EN`: when defined, adds two 32-bit wrapping output counters.
  - `stat_issued`: += n every cycle.
  - `stat_stall_cycles`: +1 each cycle where `head_valid[0]`=1 and n=0.
  - Both cleared by `reset`; not cleared by `flush`.
- When not defined: these ports and registers are absent, and behaviour is otherwise identical.

## Test plan
- Mixed grant: `head_valid`=1111, classes ALU,ALU,ALU,MEM, `mem_ready`=1 → `issue_valid`=0011, `ext_enable`=1, `ext_consumed`=1.
- MEM blocked: classes MEM,ALU,ALU,ALU, `mem_ready`=0 → `issue_valid`=0000, `ext_enable`=0. Raising `mem_ready` the next cycle → `issue_valid`=0111, `ext_consumed`=2 (third ALU denied by `ALU_PORTS`=2).
- Branch terminates group: classes ALU,BRANCH,ALU,ALU → `issue_valid`=0011, `ext_consumed`=1.
- Divider occupancy: MULDIV issued at cycle 10 → `div_busy` high for cycles 11–22; MULDIV at head during 11–22 is not granted; granted at cycle 23.
- Flush: `flush` at cycle 5 with valid ALU heads → no `ext_enable` in cycles 5–7; issue resumes at cycle 8. A second `flush` at cycle 6 extends the block through cycle 8, and issue resumes at cycle 9.
- Reset mid-divide: `reset` at cycle 15 with `div_cnt`=8 → `div_busy`=0 at cycle 16, and MULDIV is grantable at cycle 16 once `reset` is low.
